dual_fifo_wr_arb: RTL and testbench

//   Shares the dual-issue write port of one dual_fifo between two dual-issue requesters.
//   - Round-robin ownership with a burst budget of MaxBurst entries per grant.
//   - Produces only legal valid/rdy encodings on every interface (11, 01, 00; never 10).
//   - Sits between two producers (e.g. fetch and replay paths) and the FIFO write port.

---
 rtl/dual_fifo_wr_arb_if.sv | 24 ++
 rtl/dual_fifo_wr_arb.sv | 138 +++++++++++++
 tb/tb_dual_fifo_wr_arb.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_fifo_wr_arb_if.sv
// Dual-issue write port bundle: up to two sequential entries per cycle.
// valid/rdy use only the 11, 01 and 00 encodings.
interface dual_fifo_wr_arb_if #(
   parameter int Width = 32
);
   logic [1:0]       valid;
   logic [Width-1:0] data0;
   logic [Width-1:0] data1;
   logic [1:0]       rdy;

   modport master (
      output valid,
      output data0,
      output data1,
      input  rdy
   );

   modport slave (
      input  valid,
      input  data0,
      input  data1,
      output rdy
   );
endinterface

// File: rtl/dual_fifo_wr_arb.sv
// Round-robin sharing of one dual_fifo write port between two requesters.
// Define DUAL_FIFO_ARB_STATS_EN for saturating per-requester entry counters.
module dual_fifo_wr_arb #(
   parameter int Width    = 32,
   parameter int MaxBurst = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   dual_fifo_wr_arb_if.slave  req0_if,
   dual_fifo_wr_arb_if.slave  req1_if,
   dual_fifo_wr_arb_if.master fifo_if,
   output logic [15:0]        stat_cnt0_o,
   output logic [15:0]        stat_cnt1_o
);
   localparam int CntW = $clog2(MaxBurst + 1);
   localparam logic [CntW-1:0] BurstMax = CntW'(MaxBurst);
   localparam logic [CntW-1:0] LastSlot = CntW'(MaxBurst - 1);

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } owner_e;

   owner_e          owner_q, owner_d;
   logic            prio_q, prio_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] base, sum;
   logic            have, own, fresh, clamp;
   logic [1:0]      own_valid, fv, own_rdy, n;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_q <= IDLE;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         owner_q <= owner_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      have  = 1'b1;
      own   = 1'b0;
      fresh = 1'b1;
      // A continuing owner keeps the port; otherwise arbitrate with no bubble.
      if (owner_q == OWN0 && req0_if.valid[0]) begin
         fresh = 1'b0;
      end else if (owner_q == OWN1 && req1_if.valid[0]) begin
         own   = 1'b1;
         fresh = 1'b0;
      end else if (req0_if.valid[0] && req1_if.valid[0]) begin
         own = prio_q;
      end else if (req1_if.valid[0]) begin
         own = 1'b1;
      end else if (!req0_if.valid[0]) begin
         have = 1'b0;
      end

      base      = fresh ? '0 : cnt_q;
      clamp     = have && (base == LastSlot);
      own_valid = own ? req1_if.valid : req0_if.valid;

      fv      = 2'b00;
      own_rdy = 2'b00;
      if (have && !flush_i) begin
         fv      = clamp ? (own_valid & 2'b01) : own_valid;
         own_rdy = clamp ? (fifo_if.rdy & 2'b01) : fifo_if.rdy;
      end

      fifo_if.valid = fv;
      fifo_if.data0 = own ? req1_if.data0 : req0_if.data0;
      fifo_if.data1 = own ? req1_if.data1 : req0_if.data1;
      req0_if.rdy   = own ? 2'b00 : own_rdy;
      req1_if.rdy   = own ? own_rdy : 2'b00;

      if (fv == 2'b11 && fifo_if.rdy == 2'b11) begin
         n = 2'd2;
      end else if (fv[0] && fifo_if.rdy[0]) begin
         n = 2'd1;
      end else begin
         n = 2'd0;
      end
      sum = base + CntW'(n);

      owner_d = IDLE;
      cnt_d   = '0;
      prio_d  = prio_q;
      if (flush_i) begin
         prio_d = 1'b0;
      end else if (have) begin
         if (sum >= BurstMax) begin
            prio_d = ~own;
         end else begin
            owner_d = own ? OWN1 : OWN0;
            cnt_d   = sum;
            if (fresh && (own != prio_q)) begin
               prio_d = ~prio_q;
            end
         end
      end
   end

`ifdef DUAL_FIFO_ARB_STATS_EN
   logic [16:0] add0, add1;

   always_comb begin
      add0 = {1'b0, stat_cnt0_o} + (own ? 17'd0 : 17'(n));
      add1 = {1'b0, stat_cnt1_o} + (own ? 17'(n) : 17'd0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_cnt0_o <= '0;
         stat_cnt1_o <= '0;
      end else begin
         stat_cnt0_o <= add0[16] ? 16'hFFFF : add0[15:0];
         stat_cnt1_o <= add1[16] ? 16'hFFFF : add1[15:0];
      end
   end
`else
   assign stat_cnt0_o = 16'h0;
   assign stat_cnt1_o = 16'h0;
`endif

`ifdef FORMAL
   always_comb begin
      assert (fifo_if.valid != 2'b10);
      assert (req0_if.rdy != 2'b10);
      assert (req1_if.rdy != 2'b10);
      assert (!((|req0_if.rdy) && (|req1_if.rdy)));
      assert (cnt_q < BurstMax);
   end
`endif
endmodule

// File: tb/tb_dual_fifo_wr_arb.sv
// Bench for dual_fifo_wr_arb: vector table with scoreboard plus
// hand sequences for short budget, async reset and stat saturation.
module tb_dual_fifo_wr_arb;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   logic flush_a;
   logic flush_b;
   logic [15:0] a_s0, a_s1, b_s0, b_s1;

   always #5 clk = ~clk;

   dual_fifo_wr_arb_if #(.Width(W)) a_r0 ();
   dual_fifo_wr_arb_if #(.Width(W)) a_r1 ();
   dual_fifo_wr_arb_if #(.Width(W)) a_f ();
   dual_fifo_wr_arb_if #(.Width(W)) b_r0 ();
   dual_fifo_wr_arb_if #(.Width(W)) b_r1 ();
   dual_fifo_wr_arb_if #(.Width(W)) b_f ();

   dual_fifo_wr_arb #(.Width(W), .MaxBurst(4)) dut_a (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush_a),
      .req0_if    (a_r0),
      .req1_if    (a_r1),
      .fifo_if    (a_f),
      .stat_cnt0_o(a_s0),
      .stat_cnt1_o(a_s1)
   );

   dual_fifo_wr_arb #(.Width(W), .MaxBurst(3)) dut_b (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush_b),
      .req0_if    (b_r0),
      .req1_if    (b_r1),
      .fifo_if    (b_f),
      .stat_cnt0_o(b_s0),
      .stat_cnt1_o(b_s1)
   );

   typedef struct {
      logic       rs, fl;
      logic [1:0] v0, v1, fr;
      logic [1:0] fv, r0, r1;
      logic       sel;
   } vec_t;

   typedef struct {
      int          id;
      logic [1:0]  fv, r0, r1;
      logic [31:0] d0, d1;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   pass_cnt = 0;
   int   total = 0;
`ifdef DUAL_FIFO_ARB_STATS_EN
   int   m0 = 0;
   int   m1 = 0;
`endif

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic add(input logic rs, input logic fl, input logic [1:0] v0,
                      input logic [1:0] v1, input logic [1:0] fr,
                      input logic [1:0] fv, input logic [1:0] r0,
                      input logic [1:0] r1, input logic sel);
      vec_t v;
      v.rs = rs; v.fl = fl; v.v0 = v0; v.v1 = v1; v.fr = fr;
      v.fv = fv; v.r0 = r0; v.r1 = r1; v.sel = sel;
      tbl.push_back(v);
   endtask

   initial begin
      rst = 1'b1;
      flush_a = 1'b0;
      flush_b = 1'b0;
      a_r0.valid = 2'b00; a_r0.data0 = '0; a_r0.data1 = '0;
      a_r1.valid = 2'b00; a_r1.data0 = '0; a_r1.data1 = '0;
      a_f.rdy = 2'b00;
      b_r0.valid = 2'b00; b_r0.data0 = '0; b_r0.data1 = '0;
      b_r1.valid = 2'b00; b_r1.data0 = '0; b_r1.data1 = '0;
      b_f.rdy = 2'b00;

      // reset, idle
      add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      // req0 alone: burst of 4, release, regrant without bubble
      add(0, 0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      add(0, 0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      add(0, 0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      add(0, 0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      add(0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0);
      // reset, then both requesting: A,A,B,B,A,A
      add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      add(0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      add(0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      add(0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 1);
      add(0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 1);
      add(0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      add(0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      // B owns, then holds through 5 cycles of backpressure
      add(0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 1);
      for (int k = 0; k < 5; k++)
         add(0, 0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1);
      // B drops: A granted same cycle with a fresh budget
      add(0, 0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      add(0, 0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      // single-entry traffic and clamp on the last slot
      add(0, 0, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 1);
      add(0, 0, 2'b01, 2'b01, 2'b11, 2'b01, 2'b00, 2'b11, 1);
      add(0, 0, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 2'b01, 1);
      add(0, 0, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 0);
      add(0, 0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      add(0, 0, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 0);
      // flush mid-burst of B, then prio back to A
      add(0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 1);
      add(0, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1);
      add(0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 0);
      add(0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0);

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         vec_t v;
         exp_t e;
         exp_t g;
         v = tbl[i];
         rst = v.rs;
         flush_a = v.fl;
         a_r0.valid = v.v0;
         a_r0.data0 = 32'hA000_0000 + 32'(i * 16);
         a_r0.data1 = a_r0.data0 + 32'd1;
         a_r1.valid = v.v1;
         a_r1.data0 = 32'hB000_0000 + 32'(i * 16);
         a_r1.data1 = a_r1.data0 + 32'd1;
         a_f.rdy = v.fr;
         e.id = i;
         e.fv = v.fv;
         e.r0 = v.r0;
         e.r1 = v.r1;
         e.d0 = v.sel ? a_r1.data0 : a_r0.data0;
         e.d1 = v.sel ? a_r1.data1 : a_r0.data1;
         sb.push_back(e);
`ifdef DUAL_FIFO_ARB_STATS_EN
         if (v.rs) begin
            m0 = 0;
            m1 = 0;
         end else begin
            int nn;
            nn = (v.fv == 2'b11 && v.fr == 2'b11) ? 2 :
                 (v.fv[0] && v.fr[0]) ? 1 : 0;
            if (v.sel) m1 += nn;
            else m0 += nn;
         end
`endif
         @(negedge clk);
         if (sb.size() == 0) begin
            total++;
            $display("FAIL v%0d.sb: got empty want entry", i);
         end else begin
            g = sb.pop_front();
            chk($sformatf("v%0d.fv", g.id), 32'(a_f.valid), 32'(g.fv));
            chk($sformatf("v%0d.r0", g.id), 32'(a_r0.rdy), 32'(g.r0));
            chk($sformatf("v%0d.r1", g.id), 32'(a_r1.rdy), 32'(g.r1));
            if (g.fv != 2'b00) begin
               chk($sformatf("v%0d.d0", g.id), a_f.data0, g.d0);
               chk($sformatf("v%0d.d1", g.id), a_f.data1, g.d1);
            end
         end
         @(posedge clk);
         #1;
      end
      flush_a = 1'b0;
      rst = 1'b0;

`ifdef DUAL_FIFO_ARB_STATS_EN
      chk("stat0.tbl", 32'(a_s0), 32'(m0));
      chk("stat1.tbl", 32'(a_s1), 32'(m1));
`else
      chk("stat0.off", 32'(a_s0), 32'h0);
      chk("stat1.off", 32'(a_s1), 32'h0);
`endif

      // MaxBurst=3: 11 then clamped 01, release, regrant
      b_r0.valid = 2'b11;
      b_r0.data0 = 32'hC000_0000;
      b_r0.data1 = 32'hC000_0001;
      b_f.rdy = 2'b11;
      @(negedge clk);
      chk("mb3.c1.fv", 32'(b_f.valid), 32'h3);
      chk("mb3.c1.r0", 32'(b_r0.rdy), 32'h3);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mb3.c2.fv", 32'(b_f.valid), 32'h1);
      chk("mb3.c2.r0", 32'(b_r0.rdy), 32'h1);
      chk("mb3.c2.r1", 32'(b_r1.rdy), 32'h0);
      chk("mb3.c2.d0", b_f.data0, 32'hC000_0000);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mb3.c3.fv", 32'(b_f.valid), 32'h3);
      @(posedge clk);
      #1;
      b_r0.valid = 2'b00;
      b_f.rdy = 2'b00;

      // async reset mid-burst drops B's ownership immediately
      a_r0.valid = 2'b00;
      a_r1.valid = 2'b11;
      a_f.rdy = 2'b00;
      @(negedge clk);
      chk("ar.grantB", 32'(a_f.valid), 32'h3);
      @(posedge clk);
      #1;
      a_r0.valid = 2'b11;
      a_r1.valid = 2'b01;
      @(negedge clk);
      chk("ar.holdB", 32'(a_f.valid), 32'h1);
      chk("ar.holdB.d0", a_f.data0, a_r1.data0);
      #1 rst = 1'b1;
      #1;
      chk("ar.rst.fv", 32'(a_f.valid), 32'h3);
      chk("ar.rst.d0", a_f.data0, a_r0.data0);
      #1 rst = 1'b0;
      #1;
      chk("ar.rel.fv", 32'(a_f.valid), 32'h3);
      @(posedge clk);
      #1;
      chk("ar.stat0", 32'(a_s0), 32'h0);

`ifdef DUAL_FIFO_ARB_STATS_EN
      // req0 alone streams 2 entries per cycle up to saturation
      a_r1.valid = 2'b00;
      a_f.rdy = 2'b11;
      repeat (32767) @(posedge clk);
      #1;
      chk("sat.fffe", 32'(a_s0), 32'hFFFE);
      @(posedge clk);
      #1;
      chk("sat.ffff", 32'(a_s0), 32'hFFFF);
      @(posedge clk);
      #1;
      chk("sat.hold", 32'(a_s0), 32'hFFFF);
      chk("sat.s1", 32'(a_s1), 32'h0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
